memb_seq: RTL and testbench

Sequencer for the B-operand skew FIFO bank (memB) of the systolic matrix unit. It accepts DIM rows of B from an upstream producer over a valid/ready handshake and drives them into memB with a shared shift enable. It then pushes zero rows to flush the diagonal skew and generates the matching MAC-array enable. It signals completion with a one-cycle `done` pulse.

---
 rtl/memb_seq.sv | 116 +++++++++++
 tb/tb_memb_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/memb_seq.sv
// memb_seq: feeds DIM rows of B into the memB skew FIFOs, flushes the skew with zero rows, drives the MAC enable
module memb_seq #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      row_valid,
    input  logic signed [BITS_AB-1:0] row_data [DIM-1:0],
    output logic                      row_ready,
    output logic                      memb_en,
    output logic signed [BITS_AB-1:0] memb_din [DIM-1:0],
    output logic                      mac_en,
    output logic                      busy,
    output logic                      done
);
    localparam int RW = $clog2(DIM + 1);
    localparam int FW = $clog2(DIM);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             row_cnt_q, row_cnt_d;
    logic [FW-1:0]             flush_cnt_q, flush_cnt_d;
    logic                      row_ready_q, row_ready_d;
    logic                      memb_en_q, memb_en_d;
    logic signed [BITS_AB-1:0] memb_din_q [DIM-1:0];
    logic signed [BITS_AB-1:0] memb_din_d [DIM-1:0];
    logic                      mac_en_q, mac_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      hs;

    assign hs        = row_valid & row_ready_q;
    assign row_ready = row_ready_q;
    assign memb_en   = memb_en_q;
    assign memb_din  = memb_din_q;
    assign mac_en    = mac_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next state: a stall simply withholds the shift enable so all memB columns freeze together
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        flush_cnt_d = flush_cnt_q;
        memb_en_d   = 1'b0;
        memb_din_d  = memb_din_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FEED;
                    row_cnt_d   = '0;
                    flush_cnt_d = '0;
                end
            end
            FEED: begin
                if (hs) begin
                    memb_en_d  = 1'b1;
                    memb_din_d = row_data;
                    row_cnt_d  = row_cnt_q + 1'b1;
                    if (row_cnt_q == RW'(DIM - 1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                memb_en_d   = 1'b1;
                memb_din_d  = '{default: '0};
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FW'(DIM - 2)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!memb_en_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            memb_en_d = 1'b0;
            done_d    = 1'b0;
        end
        mac_en_d    = memb_en_q & ~abort;
        row_ready_d = (state_d == FEED);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; memb_din is kept stale on abort, only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            flush_cnt_q <= '0;
            row_ready_q <= 1'b0;
            memb_en_q   <= 1'b0;
            memb_din_q  <= '{default: '0};
            mac_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_ready_q <= row_ready_d;
            memb_en_q   <= memb_en_d;
            memb_din_q  <= memb_din_d;
            mac_en_q    <= mac_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_memb_seq.sv
// tb_memb_seq: cycle tables for the control outputs plus a row scoreboard for memb_din
module tb_memb_seq;
    localparam int DIM = 8;
    localparam int D2  = 2;
    localparam int W   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, abort = 1'b0, start = 1'b0, row_valid = 1'b0;
    logic start2 = 1'b0, rv2 = 1'b0;
    logic signed [W-1:0] row_data [DIM-1:0];
    logic signed [W-1:0] memb_din [DIM-1:0];
    logic signed [W-1:0] row_data2 [D2-1:0];
    logic signed [W-1:0] din2 [D2-1:0];
    logic row_ready, memb_en, mac_en, busy, done;
    logic rdy2, men2, mac2, busy2, done2;

    memb_seq #(.BITS_AB(W), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .memb_en(memb_en), .memb_din(memb_din), .mac_en(mac_en),
        .busy(busy), .done(done)
    );

    memb_seq #(.BITS_AB(W), .DIM(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort),
        .row_valid(rv2), .row_data(row_data2), .row_ready(rdy2),
        .memb_en(men2), .memb_din(din2), .mac_en(mac2),
        .busy(busy2), .done(done2)
    );

    typedef struct packed {
        bit rs, st, ab, rv;
        bit rdy, men, mac, bsy, dn;
    } vec_t;

    vec_t tbl[$];
    logic [DIM*W-1:0] sb[$];
    logic [DIM*W-1:0] hold;
    int n_vec = 0, n_bad = 0, men_cnt = 0;
    bit mon_on = 1'b0, rst_seen = 1'b0;

    function automatic bit inr(int i, int lo, int hi);
        return i >= lo && i <= hi;
    endfunction

    function automatic logic [DIM*W-1:0] pk(input logic signed [W-1:0] a [DIM-1:0]);
        logic [DIM*W-1:0] r;
        for (int c = 0; c < DIM; c++) r[c*W +: W] = a[c];
        return r;
    endfunction

    function automatic void addv(bit rs, bit st, bit ab, bit rv, bit rdy, bit men, bit mac, bit bsy, bit dn);
        tbl.push_back('{rs, st, ab, rv, rdy, men, mac, bsy, dn});
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // memb_din scoreboard: every memb_en pops the next expected row, otherwise the last value must hold
    always @(posedge clk) rst_seen <= rst;
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_seen) hold = '0;
            if (memb_en === 1'b1) begin
                men_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_empty: memb_en=1 with no expected row");
                end else hold = sb.pop_front();
            end
            chk("memb_din", pk(memb_din), hold);
        end
    end

    task automatic run(string nm, int base);
        int r = 0;
        men_cnt = 0;
        foreach (tbl[i]) begin
            rst = tbl[i].rs;
            start = tbl[i].st;
            abort = tbl[i].ab;
            row_valid = tbl[i].rv;
            for (int c = 0; c < DIM; c++) row_data[c] = W'(base + 16*r + c);
            @(negedge clk);
            chk($sformatf("%s.c%0d.row_ready", nm, i), 64'(row_ready), 64'(tbl[i].rdy));
            chk($sformatf("%s.c%0d.memb_en", nm, i), 64'(memb_en), 64'(tbl[i].men));
            chk($sformatf("%s.c%0d.mac_en", nm, i), 64'(mac_en), 64'(tbl[i].mac));
            chk($sformatf("%s.c%0d.busy", nm, i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("%s.c%0d.done", nm, i), 64'(done), 64'(tbl[i].dn));
            if (tbl[i].rv && tbl[i].rdy && !tbl[i].rs) begin
                sb.push_back(pk(row_data));
                r++;
                if (r == DIM) for (int z = 0; z < DIM - 1; z++) sb.push_back('0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        row_valid = 1'b0;
    endtask

    task automatic b2b(string nm, int st_hi, int base);
        tbl.delete();
        for (int i = 0; i < 22; i++)
            addv(0, i <= st_hi, 0, 1, inr(i, 1, 8), inr(i, 2, 16), inr(i, 3, 17), inr(i, 1, 17), i == 18);
        run(nm, base);
        chk({nm, ".men_pulses"}, 64'(men_cnt), 64'd15);
        chk({nm, ".sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int p, r2;
        logic [2*W-1:0] e2;
        for (int c = 0; c < DIM; c++) row_data[c] = '0;
        for (int c = 0; c < D2; c++) row_data2[c] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        tbl.delete();
        for (int i = 0; i < 3; i++) addv(0, 0, 0, 1, 0, 0, 0, 0, 0);
        run("idle", 0);

        b2b("b2b", 0, 0);
        b2b("start_held", 17, 3);

        tbl.delete();
        for (int i = 0; i < 24; i++)
            addv(0, i == 0, 0, !(i == 3 || i == 4 || i == 8), inr(i, 1, 11),
                 inr(i, 2, 3) || inr(i, 6, 8) || inr(i, 10, 19),
                 inr(i, 3, 4) || inr(i, 7, 9) || inr(i, 11, 20), inr(i, 1, 20), i == 21);
        run("stall", 5);
        chk("stall.men_pulses", 64'(men_cnt), 64'd15);

        tbl.delete();
        for (int i = 0; i < 8; i++)
            addv(i == 4 || i == 5, i == 0, 0, inr(i, 1, 3), inr(i, 1, 4), inr(i, 2, 4), inr(i, 3, 4), inr(i, 1, 4), 0);
        run("rst_feed", 9);
        sb.delete();
        b2b("after_rst", 0, 1);

        tbl.delete();
        for (int i = 0; i < 17; i++)
            addv(0, i == 0 || i == 13, i == 12 || i == 13, 1, inr(i, 1, 8), inr(i, 2, 12), inr(i, 3, 12), inr(i, 1, 12), 0);
        run("abort_flush", 2);
        sb.delete();
        b2b("after_abort", 0, 7);

        p = 0;
        r2 = 0;
        for (int i = 0; i < 9; i++) begin
            start2 = (i == 0);
            rv2 = 1'b1;
            for (int c = 0; c < D2; c++) row_data2[c] = W'(32 + 16*r2 + c);
            @(negedge clk);
            chk($sformatf("d2.c%0d.row_ready", i), 64'(rdy2), 64'(inr(i, 1, 2)));
            chk($sformatf("d2.c%0d.memb_en", i), 64'(men2), 64'(inr(i, 2, 4)));
            chk($sformatf("d2.c%0d.mac_en", i), 64'(mac2), 64'(inr(i, 3, 5)));
            chk($sformatf("d2.c%0d.busy", i), 64'(busy2), 64'(inr(i, 1, 5)));
            chk($sformatf("d2.c%0d.done", i), 64'(done2), 64'(i == 6));
            if (inr(i, 2, 4)) begin
                e2 = (i == 4) ? '0 : {W'(32 + 16*(i-2) + 1), W'(32 + 16*(i-2))};
                chk($sformatf("d2.c%0d.memb_din", i), 64'({din2[1], din2[0]}), 64'(e2));
            end
            if (men2 === 1'b1) p++;
            if (inr(i, 1, 2)) r2++;
            @(posedge clk);
            #1;
        end
        start2 = 1'b0;
        rv2 = 1'b0;
        chk("d2.men_pulses", 64'(p), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
